// File: rtl/prog_loader.sv
// Boot loader: streams a program/data image over valid/ready into the unified
// memory from address 0, optionally zero-fills the remainder, then releases the core.
module prog_loader #(
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter bit ZERO_FILL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_run,
  output logic [ADDR_W:0]   words_loaded,
  output logic              trunc
);

  typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              xfer;
  logic              at_last_addr;

  // Ready is a pure function of state so upstream never sees a valid->ready loop.
  assign in_ready     = (state == LOAD);
  assign xfer         = in_valid && in_ready;
  assign at_last_addr = (wr_ptr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      core_run     <= 1'b0;
      words_loaded <= '0;
      trunc        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_we <= 1'b0;
          if (load_req) begin
            state        <= LOAD;
            wr_ptr       <= '0;
            words_loaded <= '0;
            trunc        <= 1'b0;
          end
        end
        LOAD: begin
          mem_we <= xfer;
          if (xfer) begin
            mem_addr     <= wr_ptr;
            mem_wdata    <= in_data;
            words_loaded <= words_loaded + (ADDR_W + 1)'(1);
            // The pointer parks on the top address so it never wraps.
            if (!at_last_addr)
              wr_ptr <= wr_ptr + ADDR_W'(1);
            if (at_last_addr && !in_last)
              trunc <= 1'b1;
            if (in_last || at_last_addr)
              state <= (ZERO_FILL && !at_last_addr) ? FILL : DONE;
          end
        end
        FILL: begin
          mem_we    <= 1'b1;
          mem_addr  <= wr_ptr;
          mem_wdata <= '0;
          if (at_last_addr)
            state <= DONE;
          else
            wr_ptr <= wr_ptr + ADDR_W'(1);
        end
        DONE: begin
          mem_we <= 1'b0;
          // core_run trails the final write by a cycle so memory is settled at fetch.
          if (load_req) begin
            state        <= LOAD;
            core_run     <= 1'b0;
            wr_ptr       <= '0;
            words_loaded <= '0;
            trunc        <= 1'b0;
          end else begin
            core_run <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: one instance with zero-fill, one without,
// sharing the same stream; monitors pop expected writes as mem_we appears.
module tb_prog_loader;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_req;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  logic              in_ready_a, mem_we_a, core_run_a, trunc_a;
  logic [ADDR_W-1:0] mem_addr_a;
  logic [DATA_W-1:0] mem_wdata_a;
  logic [ADDR_W:0]   words_loaded_a;
  logic              in_ready_b, mem_we_b, core_run_b, trunc_b;
  logic [ADDR_W-1:0] mem_addr_b;
  logic [DATA_W-1:0] mem_wdata_b;
  logic [ADDR_W:0]   words_loaded_b;

  always #5 clk = ~clk;

  prog_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_FILL(1'b1)) dut_a (
    .clk(clk), .reset(reset), .load_req(load_req), .in_valid(in_valid),
    .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .core_run(core_run_a), .words_loaded(words_loaded_a), .trunc(trunc_a)
  );

  prog_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_FILL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .load_req(load_req), .in_valid(in_valid),
    .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .core_run(core_run_b), .words_loaded(words_loaded_b), .trunc(trunc_b)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t q_a[$];
  wr_t q_b[$];
  wr_t e_a, e_b;
  int  checks = 0;
  int  errors = 0;
  int  exp_ptr = 0;

  logic [31:0] img [14] = '{
    32'h4001000D, 32'h0C002013, 32'h10403023, 32'h20004033, 32'h3000A0B3,
    32'h5000B113, 32'h60001193, 32'h70102223, 32'h8020C2B3, 32'h9000D313,
    32'hA0000393, 32'hDEADBEEF, 32'h00000001, 32'hFC000000
  };

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we_a === 1'b1) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL wr_a unexpected write addr=%0d data=%h expected none", mem_addr_a, mem_wdata_a);
      end else begin
        e_a = q_a.pop_front();
        if (mem_addr_a !== e_a.addr || mem_wdata_a !== e_a.data) begin
          errors++;
          $display("FAIL wr_a actual addr=%0d data=%h expected addr=%0d data=%h",
                   mem_addr_a, mem_wdata_a, e_a.addr, e_a.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mem_we_b === 1'b1) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL wr_b unexpected write addr=%0d data=%h expected none", mem_addr_b, mem_wdata_b);
      end else begin
        e_b = q_b.pop_front();
        if (mem_addr_b !== e_b.addr || mem_wdata_b !== e_b.data) begin
          errors++;
          $display("FAIL wr_b actual addr=%0d data=%h expected addr=%0d data=%h",
                   mem_addr_b, mem_wdata_b, e_b.addr, e_b.data);
        end
      end
    end
  end

  task automatic push_word(input logic [31:0] d);
    wr_t w;
    w.addr = ADDR_W'(exp_ptr);
    w.data = d;
    q_a.push_back(w);
    q_b.push_back(w);
    exp_ptr++;
  endtask

  task automatic fill_expect();
    wr_t w;
    for (int a = exp_ptr; a < DEPTH; a++) begin
      w.addr = ADDR_W'(a);
      w.data = '0;
      q_a.push_back(w);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic start_load();
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
    exp_ptr = 0;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    bit ok = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready_a === 1'b1) begin
        push_word(d);
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted data=%h", d);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Cycles from the accepting edge of the final word until core_run is seen high.
  task automatic wait_run(input string name, input int exp_ca, input int exp_cb);
    int ca = 0;
    int cb = 0;
    for (int c = 1; c <= 60 && (ca == 0 || cb == 0); c++) begin
      @(posedge clk);
      #1;
      if (ca == 0 && core_run_a === 1'b1) ca = c;
      if (cb == 0 && core_run_b === 1'b1) cb = c;
    end
    chk({name, "_run_lat_a"}, ca, exp_ca);
    chk({name, "_run_lat_b"}, cb, exp_cb);
    chk({name, "_q_a_empty"}, q_a.size(), 0);
    chk({name, "_q_b_empty"}, q_b.size(), 0);
  endtask

  initial begin
    int k;
    int idx;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    // reset state
    do_reset(2);
    @(negedge clk);
    chk("rst_in_ready", {in_ready_a, in_ready_b}, 2'b00);
    chk("rst_mem_we", {mem_we_a, mem_we_b}, 2'b00);
    chk("rst_core_run", {core_run_a, core_run_b}, 2'b00);
    chk("rst_trunc", {trunc_a, trunc_b}, 2'b00);
    chk("rst_words_a", words_loaded_a, 0);
    chk("rst_words_b", words_loaded_b, 0);
    chk("rst_mem_addr", {mem_addr_a, mem_addr_b}, 0);
    @(posedge clk);
    #1;

    // 14-word image with in_last; a fills 14..31, b stops
    start_load();
    for (int i = 0; i < 14; i++) send(img[i], i == 13);
    fill_expect();
    wait_run("img14", 19, 1);
    chk("img14_words_a", words_loaded_a, 14);
    chk("img14_words_b", words_loaded_b, 14);
    chk("img14_trunc", {trunc_a, trunc_b}, 2'b00);
    chk("img14_mem_we_done", {mem_we_a, mem_we_b}, 2'b00);

    // 32 words without in_last: truncated, no fill
    start_load();
    for (int i = 0; i < 32; i++) send((i == 31) ? 32'd21 : (32'hA5000000 + i), 1'b0);
    fill_expect();
    wait_run("full_nolast", 1, 1);
    chk("full_nolast_words_a", words_loaded_a, 32);
    chk("full_nolast_words_b", words_loaded_b, 32);
    chk("full_nolast_trunc", {trunc_a, trunc_b}, 2'b11);

    // 32 words with in_last on the final word: not truncated
    start_load();
    for (int i = 0; i < 32; i++) send(32'h5A000000 ^ (i * 32'h01010101), i == 31);
    fill_expect();
    wait_run("full_last", 1, 1);
    chk("full_last_words_a", words_loaded_a, 32);
    chk("full_last_trunc", {trunc_a, trunc_b}, 2'b00);

    // backpressure: valid pattern 1,0,0,1,1,0 repeating, 6 words
    start_load();
    k = 0;
    idx = 0;
    while (k < 6 && idx < 40) begin
      in_valid = pat[idx % 6];
      in_data  = 32'hB0000000 + k;
      in_last  = (k == 5);
      @(negedge clk);
      chk("bp_in_ready_a", in_ready_a, 1'b1);
      chk("bp_in_ready_b", in_ready_b, 1'b1);
      if (in_valid && in_ready_a === 1'b1) begin
        push_word(in_data);
        k++;
      end
      @(posedge clk);
      #1;
      idx++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp_words_sent", k, 6);
    fill_expect();
    wait_run("bp", 27, 1);
    chk("bp_words_a", words_loaded_a, 6);
    chk("bp_words_b", words_loaded_b, 6);

    // reload from DONE with a single word
    start_load();
    chk("reload_core_run_drop", {core_run_a, core_run_b}, 2'b00);
    chk("reload_words_clr", words_loaded_b, 0);
    send(32'h13579BDF, 1'b1);
    fill_expect();
    wait_run("single", 32, 1);
    chk("single_words_b", words_loaded_b, 1);
    chk("single_trunc", {trunc_a, trunc_b}, 2'b00);

    // reset in the middle of a load
    start_load();
    for (int i = 0; i < 5; i++) send(32'hC0DE0000 + i, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midrst_mem_we", {mem_we_a, mem_we_b}, 2'b00);
    chk("midrst_in_ready", {in_ready_a, in_ready_b}, 2'b00);
    chk("midrst_words_a", words_loaded_a, 0);
    chk("midrst_core_run", {core_run_a, core_run_b}, 2'b00);
    in_valid = 1'b1; in_last = 1'b1; in_data = 32'hFFFF0000;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_accept", {in_ready_a, in_ready_b}, 2'b00);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("midrst_words_after", {words_loaded_a, words_loaded_b}, 0);
    chk("midrst_q_a_empty", q_a.size(), 0);
    chk("midrst_q_b_empty", q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
